// File: rtl/alu_m_pkg.sv
// alu_m_pkg
// Shared types and constants for the RV32M execution unit.
//   alu_m_op_e    : RV32M funct3 encodings (MUL .. REMU)
//   alu_m_state_e : execution FSM states
//   DIV_ITER      : number of restoring-divide iterations
//   abs_if        : two's-complement magnitude when the operand is treated as signed
package alu_m_pkg;

    typedef enum logic [2:0] {
        ALU_M_MUL    = 3'b000,
        ALU_M_MULH   = 3'b001,
        ALU_M_MULHSU = 3'b010,
        ALU_M_MULHU  = 3'b011,
        ALU_M_DIV    = 3'b100,
        ALU_M_DIVU   = 3'b101,
        ALU_M_REM    = 3'b110,
        ALU_M_REMU   = 3'b111
    } alu_m_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_m_state_e;

    localparam int DIV_ITER = 32;

    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/alu_m_divider.sv
// alu_m_divider
// Iterative unsigned restoring divider, one quotient bit per cycle.
// The start edge loads the operands; the following DIV_ITER edges each
// produce one quotient bit, after which done_o is held high until the
// next start or flush. The divisor must be non-zero (caller handles /0).
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   flush_i        : abandon the current division
//   start_i        : load dividend_i / divisor_i and begin
//   dividend_i     : 32-bit unsigned dividend
//   divisor_i      : 32-bit unsigned divisor (non-zero)
//   quotient_o     : 32-bit quotient (valid while done_o)
//   remainder_o    : 32-bit remainder (valid while done_o)
//   done_o         : result available
module alu_m_divider
    import alu_m_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush_i,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        done_o
);

    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] div_q;
    logic [5:0]  cnt_q;
    logic        busy_q;
    logic        done_q;

    logic [32:0] shift_w;
    logic [32:0] trial_w;
    logic [31:0] rem_d;
    logic [31:0] quo_d;

    // Partial remainder shifted left with the next dividend bit. A
    // negative trial difference (bit 32 set) means the divisor did not fit
    // and the shifted value is kept unchanged (the "restore").
    assign shift_w = {rem_q, quo_q[31]};
    assign trial_w = shift_w - {1'b0, div_q};
    assign rem_d   = trial_w[32] ? shift_w[31:0] : trial_w[31:0];
    assign quo_d   = {quo_q[30:0], ~trial_w[32]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (flush_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            quo_q  <= dividend_i;
            rem_q  <= '0;
            div_q  <= divisor_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            if (cnt_q == 6'(DIV_ITER - 1)) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 6'd1;
            end
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign done_o      = done_q;

endmodule

// File: rtl/alu_m_execute_unit.sv
// alu_m_execute_unit
// RV32M multiply/divide execution unit behind the ALU_M reservation station.
// Accepts one op when idle, computes it over several cycles, then holds the
// result on the CDB request port until the arbiter grants.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   i_flush          : drop in-flight op and any pending result
//   i_alu_ex_en      : dispatch strobe (ignored while busy)
//   i_alu_opcode     : RV32M funct3
//   i_rs1_value      : operand A
//   i_rs2_value      : operand B
//   i_rob_addr       : destination ROB tag
//   o_alu_busy       : unit cannot accept a dispatch
//   o_cdb_valid      : result pending broadcast
//   o_cdb_rob_addr   : result ROB tag
//   o_cdb_data       : result value
//   i_cdb_grant      : arbiter takes the result this cycle
module alu_m_execute_unit
    import alu_m_pkg::*;
#(
    parameter int ROBSIZE = 8,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_flush,
    input  logic               i_alu_ex_en,
    input  logic [2:0]         i_alu_opcode,
    input  logic [31:0]        i_rs1_value,
    input  logic [31:0]        i_rs2_value,
    input  logic [ROBSIZE-1:0] i_rob_addr,
    output logic               o_alu_busy,
    output logic               o_cdb_valid,
    output logic [ROBSIZE-1:0] o_cdb_rob_addr,
    output logic [31:0]        o_cdb_data,
    input  logic               i_cdb_grant
);

    localparam int MCW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT);

    alu_m_state_e       state_q, state_d;
    alu_m_op_e          op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [ROBSIZE-1:0] tag_q, tag_d;
    logic               neg_q, neg_d;
    logic               special_q, special_d;
    logic [MCW-1:0]     mcnt_q, mcnt_d;
    logic [31:0]        data_q, data_d;
    logic               busy_q;
    logic               valid_q;

    // Dispatch-side decode of the incoming operation.
    logic in_div_w, in_sgn_w, in_rem_w, in_div0_w, in_ovf_w;
    logic accept_w, div_start_w;
    logic [31:0] special_res_w;

    assign in_div_w  = i_alu_opcode[2];
    assign in_sgn_w  = ~i_alu_opcode[0];
    assign in_rem_w  = i_alu_opcode[1];
    assign in_div0_w = (i_rs2_value == 32'd0);
    assign in_ovf_w  = in_sgn_w && (i_rs1_value == 32'h8000_0000)
                                && (i_rs2_value == 32'hFFFF_FFFF);

    assign accept_w    = (state_q == ST_IDLE) && i_alu_ex_en && !i_flush;
    assign div_start_w = accept_w && in_div_w && !in_div0_w && !in_ovf_w;

    // Results that need no iteration: /0 and signed overflow.
    assign special_res_w = in_div0_w ? (in_rem_w ? i_rs1_value : 32'hFFFF_FFFF)
                                     : (in_rem_w ? 32'd0       : 32'h8000_0000);

    // Multiplier: 33x33 signed product of sign- or zero-extended operands.
    // Only the low 64 bits of the 66-bit product are ever needed.
    logic [32:0] mul_a_w, mul_b_w;
    logic [63:0] prod_w;

    assign mul_a_w = {(op_q != ALU_M_MULHU) & a_q[31], a_q};
    assign mul_b_w = {(op_q == ALU_M_MULH)  & b_q[31], b_q};
    assign prod_w  = $signed({{31{mul_a_w[32]}}, mul_a_w})
                   * $signed({{31{mul_b_w[32]}}, mul_b_w});

    // Divider operates on magnitudes; sign is restored on exit.
    logic [31:0] quo_w, rem_w, div_sel_w;
    logic        div_done_w;

    alu_m_divider u_divider (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (i_flush),
        .start_i     (div_start_w),
        .dividend_i  (abs_if(i_rs1_value, in_sgn_w)),
        .divisor_i   (abs_if(i_rs2_value, in_sgn_w)),
        .quotient_o  (quo_w),
        .remainder_o (rem_w),
        .done_o      (div_done_w)
    );

    assign div_sel_w = op_q[1] ? rem_w : quo_w;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = tag_q;
        neg_d     = neg_q;
        special_d = special_q;
        mcnt_d    = mcnt_q;
        data_d    = data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_w) begin
                    op_d      = alu_m_op_e'(i_alu_opcode);
                    a_d       = i_rs1_value;
                    b_d       = i_rs2_value;
                    tag_d     = i_rob_addr;
                    mcnt_d    = '0;
                    // REM follows the dividend's sign; DIV negates on differing signs.
                    neg_d     = in_sgn_w && (in_rem_w ? i_rs1_value[31]
                                                      : (i_rs1_value[31] ^ i_rs2_value[31]));
                    special_d = in_div_w && (in_div0_w || in_ovf_w);
                    if (!in_div_w) begin
                        state_d = ST_MUL;
                    end else begin
                        state_d = ST_DIV;
                        if (in_div0_w || in_ovf_w) begin
                            data_d = special_res_w;
                        end
                    end
                end
            end
            ST_MUL: begin
                if (mcnt_q == MCW'(MUL_LAT - 1)) begin
                    state_d = ST_DONE;
                    mcnt_d  = '0;
                    data_d  = (op_q == ALU_M_MUL) ? prod_w[31:0] : prod_w[63:32];
                end else begin
                    mcnt_d = mcnt_q + 1'b1;
                end
            end
            ST_DIV: begin
                // Special cases spend exactly one cycle here with the result
                // already loaded; the divider was never started for them.
                if (special_q) begin
                    state_d   = ST_DONE;
                    special_d = 1'b0;
                end else if (div_done_w) begin
                    state_d = ST_DONE;
                    data_d  = neg_q ? (~div_sel_w + 32'd1) : div_sel_w;
                end
            end
            ST_DONE: begin
                if (i_cdb_grant) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_flush) begin
            state_d   = ST_IDLE;
            mcnt_d    = '0;
            special_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            op_q      <= ALU_M_MUL;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            mcnt_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            mcnt_q    <= mcnt_d;
            data_q    <= data_d;
            busy_q    <= (state_d != ST_IDLE);
            valid_q   <= (state_d == ST_DONE);
        end
    end

    assign o_alu_busy     = busy_q;
    assign o_cdb_valid    = valid_q;
    assign o_cdb_rob_addr = tag_q;
    assign o_cdb_data     = data_q;

endmodule

// File: tb/tb_alu_m_execute_unit.sv
// Testbench for alu_m_execute_unit: scoreboard of expected results pushed at
// dispatch and popped when the CDB request appears.
module tb_alu_m_execute_unit;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        ex_en;
    logic [2:0]  opcode;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [7:0]  rob;
    logic        busy;
    logic        cdb_valid;
    logic [7:0]  cdb_rob;
    logic [31:0] cdb_data;
    logic        grant;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [7:0]  lat;
    } vec_t;

    alu_m_execute_unit #(.ROBSIZE(8), .MUL_LAT(2)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_flush        (flush),
        .i_alu_ex_en    (ex_en),
        .i_alu_opcode   (opcode),
        .i_rs1_value    (rs1),
        .i_rs2_value    (rs2),
        .i_rob_addr     (rob),
        .o_alu_busy     (busy),
        .o_cdb_valid    (cdb_valid),
        .o_cdb_rob_addr (cdb_rob),
        .o_cdb_data     (cdb_data),
        .i_cdb_grant    (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference behaviour using plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = 64'(sa / sb);
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : (a / b);
            3'd6: begin
                if (b == 32'd0) return a;
                p = 64'(sa % sb);
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : (a % b);
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (!op[2]) return 2;
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Present one dispatch for exactly one edge (E0); returns #1 after E0.
    task automatic dispatch(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [7:0] tag);
        @(negedge clk);
        ex_en  = 1'b1;
        opcode = op;
        rs1    = a;
        rs2    = b;
        rob    = tag;
        @(posedge clk);
        #1;
        ex_en = 1'b0;
    endtask

    // Count edges until o_cdb_valid, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!cdb_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] tag, input logic [31:0] exp, input int lat);
        int   n;
        exp_t e;
        sb_q.push_back('{tag: tag, data: exp});
        dispatch(op, a, b, tag);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_valid(n);
        chk("latency", 32'(n), 32'(lat));
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("cdb_data", cdb_data, e.data);
            chk("cdb_tag", {24'd0, cdb_rob}, {24'd0, e.tag});
        end
        $display("op=%0d a=%h b=%h tag=%0d lat=%0d data=%h exp=%h",
                 op, a, b, tag, n, cdb_data, exp);
        grant = 1'b1;
        @(posedge clk);
        #1;
        grant = 1'b0;
        chk("valid_after_grant", {31'd0, cdb_valid}, 32'd0);
        chk("busy_after_grant", {31'd0, busy}, 32'd0);
    endtask

    localparam int NV = 13;
    vec_t vecs [NV] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 8'd2},
        '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 8'd2},
        '{3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 8'd2},
        '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 8'd2},
        '{3'd5, 32'd100,        32'd7,         32'd14,        8'd33},
        '{3'd7, 32'd100,        32'd7,         32'd2,         8'd33},
        '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 8'd33},
        '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 8'd33},
        '{3'd4, 32'd1234,       32'd0,         32'hFFFF_FFFF, 8'd1},
        '{3'd6, 32'd5,          32'd0,         32'd5,         8'd1},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8'd1},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         8'd1},
        '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         8'd33}
    };

    initial begin
        int          n;
        int          seen;
        logic [31:0] d0;
        logic [7:0]  t0;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        rstn   = 1'b0;
        flush  = 1'b0;
        ex_en  = 1'b0;
        opcode = '0;
        rs1    = '0;
        rs2    = '0;
        rob    = '0;
        grant  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, cdb_valid}, 32'd0);
        chk("rst_tag", {24'd0, cdb_rob}, 32'd0);
        chk("rst_data", cdb_data, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // First op with grant held high throughout.
        grant = 1'b1;
        run_op(vecs[0].op, vecs[0].a, vecs[0].b, 8'd3, vecs[0].exp, int'(vecs[0].lat));

        for (int i = 1; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 8'(i + 16), vecs[i].exp,
                   int'(vecs[i].lat));
        end

        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom);
            run_op(rop, ra, rb, 8'(i + 64), model(rop, ra, rb), model_lat(rop, ra, rb));
        end

        // Backpressure: grant held low, a dispatch attempt in the middle.
        dispatch(3'd0, 32'd12, 32'd11, 8'd42);
        wait_valid(n);
        chk("bp_latency", 32'(n), 32'd2);
        chk("bp_data", cdb_data, 32'd132);
        d0 = cdb_data;
        t0 = cdb_rob;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ex_en  = 1'b1;
                opcode = 3'd1;
                rs1    = 32'd5;
                rs2    = 32'd6;
                rob    = 8'd99;
            end
            @(posedge clk);
            #1;
            ex_en = 1'b0;
            chk("bp_data_stable", cdb_data, d0);
            chk("bp_tag_stable", {24'd0, cdb_rob}, {24'd0, t0});
            chk("bp_busy", {31'd0, busy}, 32'd1);
            chk("bp_valid", {31'd0, cdb_valid}, 32'd1);
        end
        $display("backpressure tag=%0d data=%h", cdb_rob, cdb_data);
        grant = 1'b1;
        @(posedge clk);
        #1;
        grant = 1'b0;
        chk("bp_idle_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (cdb_valid || busy) seen++;
        end
        chk("bp_dispatch_ignored", 32'(seen), 32'd0);

        // Flush during a divide at cycle 10.
        dispatch(3'd5, 32'd1000, 32'd3, 8'd7);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_div_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (cdb_valid) seen++;
        end
        chk("flush_div_novalid", 32'(seen), 32'd0);
        $display("flush during divide busy=%0d valid_seen=%0d", busy, seen);

        // Flush wins over a same-cycle dispatch.
        @(negedge clk);
        ex_en  = 1'b1;
        flush  = 1'b1;
        opcode = 3'd0;
        rs1    = 32'd2;
        rs2    = 32'd3;
        rob    = 8'd8;
        @(posedge clk);
        #1;
        ex_en = 1'b0;
        flush = 1'b0;
        chk("flush_vs_dispatch_busy", {31'd0, busy}, 32'd0);

        // Flush in DONE with a simultaneous grant.
        dispatch(3'd6, 32'd5, 32'd0, 8'd9);
        wait_valid(n);
        chk("flush_done_latency", 32'(n), 32'd1);
        flush = 1'b1;
        grant = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        grant = 1'b0;
        chk("flush_done_valid", {31'd0, cdb_valid}, 32'd0);
        chk("flush_done_busy", {31'd0, busy}, 32'd0);
        $display("flush in done valid=%0d busy=%0d", cdb_valid, busy);

        // Normal operation after flushes.
        run_op(3'd0, 32'd6, 32'd7, 8'd5, 32'd42, 2);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
